trap_commit_unit: RTL and testbench
===================================

# trap_commit_unit

Write-back-stage consumer of the exception pack that the MEM-stage exception checker registers into WB. It accepts one precise trap or one `mret`/`sret` per event and decides the target privilege, including delegation. It then sequences the architectural CSR updates through a single CSR write port, one CSR per cycle, while holding the pipeline. Finally it redirects fetch to the trap vector or return address and updates the current privilege level.

## Interface
- No parameters.
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `except_wb`  in  ExceptStruct::ExceptPack  fields `except`, `epc[63:0]`, `ecause[63:0]`, `etval[63:0]`
- `valid_wb`  in  1  WB instruction valid
- `mret_wb`, `sret_wb`  in  1 each  valid xRET retiring in WB
- `mstatus_i`  in  64  current mstatus
- `medeleg_i`, `mideleg_i`  in  64 each  delegation masks
- `mtvec_i`, `stvec_i`, `mepc_i`, `sepc_i`  in  64 each  CSR read values
- `csr_we`  out  1  CSR write strobe
- `csr_waddr`  out  12  CSR address
- `csr_wdata`  out  64  CSR data
- `trap_busy`  out  1  stall for IF..WB
- `flush_all`  out  1  flush every pipeline register
- `redirect_valid`  out  1  one-cycle PC redirect
- `redirect_pc`  out  64  redirect target
- `priv`  out  2  current privilege (11 = M, 01 = S, 00 = U)

## Operation
- **Accept condition.** `take_trap = valid_wb & except_wb.except`; `take_ret = valid_wb & ~except_wb.except & (mret_wb | sret_wb)`.
- **Priority.** A trap beats a return. `mret_wb` beats `sret_wb`. Events are accepted only in IDLE.
- **Trap target.**
  - `intr = ecause[63]`, `idx = ecause[5:0]`.
  - Target is S if `priv != 11` and the selected mask bit (`mideleg_i[idx]` when `intr`, else `medeleg_i[idx]`) is 1. Otherwise the target is M.
  - Latched at accept: target, epc, ecause, etval, old priv.
- **Trap states.** IDLE → W_CAUSE → W_EPC → W_TVAL → W_STATUS → REDIRECT → IDLE.
  - W_CAUSE writes 0x342 (M target) or 0x142 (S target), data = ecause.
  - W_EPC writes 0x341 / 0x141, data = epc.
  - W_TVAL writes 0x343 / 0x143, data = etval.
  - W_STATUS writes 0x300, data = `mstatus_i` with edits:
    - M target: bit7 (MPIE) ← bit3 (MIE); bit3 ← 0; [12:11] (MPP) ← old priv.
    - S target: bit5 (SPIE) ← bit1 (SIE); bit1 ← 0; bit8 (SPP) ← old priv[0].
  - REDIRECT: `redirect_pc = {tvec[63:2], 2'b00}` of the target (direct mode only). `priv` ← target at the end of this cycle.
- **Return states.** IDLE → R_STATUS → REDIRECT → IDLE.
  - `mret`: priv ← MPP; MIE ← MPIE; MPIE ← 1; MPP ← 00; target = `mepc_i`.
  - `sret`: priv ← {1'b0, SPP}; SIE ← SPIE; SPIE ← 1; SPP ← 0; target = `sepc_i`.
  - The new priv and the target are latched in R_STATUS.
- **Outputs.**
  - `csr_we` = 1 only in the four write states.
  - `flush_all` = 1 in REDIRECT.
  - `trap_busy = accept | (state != IDLE)`.

## Timing
- **Reset values.** state = IDLE, `priv` = 11. All other outputs 0: `csr_we`, `csr_waddr`, `csr_wdata`, `trap_busy`, `flush_all`, `redirect_valid`, `redirect_pc`.
- **Trap latency.** Accept at cycle 0 (`trap_busy` = 1 combinationally). CSR writes in cycles 1–4. `redirect_valid` and `flush_all` in cycle 5. `priv` is new from cycle 6. First new fetch is in cycle 6.
- **Return latency.** Accept at cycle 0, status write in cycle 1, redirect in cycle 2, `priv` new from cycle 3.
- **No re-accept while busy.** `valid_wb` is ignored while state != IDLE. The pipeline is stalled, so WB holds and is then flushed.
- `mstatus_i` is sampled in W_STATUS / R_STATUS. Earlier writes in the sequence never touch mstatus.
- **Reset mid-sequence.** Returns to IDLE next edge. Remaining writes and the redirect are dropped. `priv` = 11.
- **Back-to-back.** A trap presented in the cycle after REDIRECT is accepted normally (state is IDLE).

## Structure
- ExceptStruct package holds:
  - ExceptPack.
  - CSR address constants: MSTATUS, MEPC, MCAUSE, MTVAL, SEPC, SCAUSE, STVAL.
  - Privilege constants.
  - mstatus bit-index constants.
  - State enum `TrapState`.
- One natural sub-module: `trap_target_sel`, combinational delegation and target-priv decision.

## Test plan
- **M-mode illegal instruction.** priv = 11, ecause = 2, epc = 0x8000_0010, etval = 0x0000_FFFF, mtvec = 0x8000_0101.
  - Writes 0x342=2, 0x341=0x80000010, 0x343=0xFFFF, 0x300 with MIE→MPIE, MPP = 11.
  - redirect_pc = 0x8000_0100 in cycle 5; priv stays 11.
- **Delegated ecall from U.** priv = 00, ecause = 8, medeleg[8] = 1, stvec = 0x8020_0000.
  - Writes 0x142/0x141/0x143; 0x300 with SPP = 0, SIE cleared.
  - redirect to 0x8020_0000; priv = 01.
- **Delegation ignored in M.** Same as the previous case with priv = 11: M target, 0x342 written, priv stays 11.
- **mret.** MPP = 00, MPIE = 1, mepc = 0x1000.
  - 0x300 written with MIE = 1, MPIE = 1, MPP = 00.
  - redirect 0x1000 in cycle 2; priv = 00.
- **Trap and mret together.** except and mret asserted in the same cycle: trap sequence runs, mret ignored.
- **Reset mid-sequence.** rst asserted in W_EPC: the next cycle has IDLE, `csr_we` = 0, no redirect, priv = 11.

Source files
------------

// File: rtl/trap_commit_unit_pkg.sv
// Shared types and constants for the write-back trap/xRET commit logic:
// the exception pack from MEM, CSR addresses, privilege encodings and mstatus fields.
package ExceptStruct;

   typedef struct packed {
      logic        except;
      logic [63:0] epc;
      logic [63:0] ecause;
      logic [63:0] etval;
   } ExceptPack;

   localparam logic [11:0] MSTATUS = 12'h300;
   localparam logic [11:0] MEPC    = 12'h341;
   localparam logic [11:0] MCAUSE  = 12'h342;
   localparam logic [11:0] MTVAL   = 12'h343;
   localparam logic [11:0] SEPC    = 12'h141;
   localparam logic [11:0] SCAUSE  = 12'h142;
   localparam logic [11:0] STVAL   = 12'h143;

   localparam logic [1:0] PRIV_M = 2'b11;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_U = 2'b00;

   localparam int SIE_BIT  = 1;
   localparam int MIE_BIT  = 3;
   localparam int SPIE_BIT = 5;
   localparam int MPIE_BIT = 7;
   localparam int SPP_BIT  = 8;
   localparam int MPP_LO   = 11;
   localparam int MPP_HI   = 12;

   typedef enum logic [2:0] {
      IDLE,
      W_CAUSE,
      W_EPC,
      W_TVAL,
      W_STATUS,
      R_STATUS,
      REDIRECT
   } TrapState;

   // mstatus image written on trap entry: stack the interrupt enable and record the old privilege.
   function automatic logic [63:0] trap_status(input logic [63:0] ms, input logic to_s,
                                               input logic [1:0] old_priv);
      logic [63:0] r;
      r = ms;
      if (to_s) begin
         r[SPIE_BIT] = ms[SIE_BIT];
         r[SIE_BIT]  = 1'b0;
         r[SPP_BIT]  = old_priv[0];
      end else begin
         r[MPIE_BIT]        = ms[MIE_BIT];
         r[MIE_BIT]         = 1'b0;
         r[MPP_HI:MPP_LO]   = old_priv;
      end
      return r;
   endfunction

   // mstatus image written on xRET: restore the stacked enable and clear the previous privilege.
   function automatic logic [63:0] ret_status(input logic [63:0] ms, input logic is_mret);
      logic [63:0] r;
      r = ms;
      if (is_mret) begin
         r[MIE_BIT]        = ms[MPIE_BIT];
         r[MPIE_BIT]       = 1'b1;
         r[MPP_HI:MPP_LO]  = PRIV_U;
      end else begin
         r[SIE_BIT]  = ms[SPIE_BIT];
         r[SPIE_BIT] = 1'b1;
         r[SPP_BIT]  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/trap_commit_unit_target_sel.sv
// Combinational delegation check: decides whether a trap lands in S or M mode.
module trap_target_sel
   import ExceptStruct::*;
(
   input  logic [1:0]  cur_priv,
   input  logic        intr,
   input  logic [5:0]  idx,
   input  logic [63:0] medeleg_i,
   input  logic [63:0] mideleg_i,
   output logic        to_s,
   output logic [1:0]  target_priv
);

   logic deleg_bit;

   // Delegation never lowers the privilege of a trap taken from M mode.
   always_comb begin
      deleg_bit   = intr ? mideleg_i[idx] : medeleg_i[idx];
      to_s        = (cur_priv != PRIV_M) && deleg_bit;
      target_priv = to_s ? PRIV_S : PRIV_M;
   end

endmodule

// File: rtl/trap_commit_unit.sv
// Write-back trap/xRET sequencer: one CSR write per cycle through a single port,
// then a fetch redirect and the privilege update.
module trap_commit_unit
   import ExceptStruct::*;
(
   input  logic        clk,
   input  logic        rst,
   input  ExceptPack   except_wb,
   input  logic        valid_wb,
   input  logic        mret_wb,
   input  logic        sret_wb,
   input  logic [63:0] mstatus_i,
   input  logic [63:0] medeleg_i,
   input  logic [63:0] mideleg_i,
   input  logic [63:0] mtvec_i,
   input  logic [63:0] stvec_i,
   input  logic [63:0] mepc_i,
   input  logic [63:0] sepc_i,
   output logic        csr_we,
   output logic [11:0] csr_waddr,
   output logic [63:0] csr_wdata,
   output logic        trap_busy,
   output logic        flush_all,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic [1:0]  priv
);

   TrapState    state_q, state_d;
   logic [1:0]  priv_q, priv_d;
   logic [1:0]  new_priv_q, new_priv_d;
   logic [1:0]  old_priv_q, old_priv_d;
   logic        tgt_s_q, tgt_s_d;
   logic        is_ret_q, is_ret_d;
   logic        is_mret_q, is_mret_d;
   logic [63:0] epc_q, epc_d;
   logic [63:0] ecause_q, ecause_d;
   logic [63:0] etval_q, etval_d;
   logic [63:0] ret_pc_q, ret_pc_d;

   logic        take_trap;
   logic        take_ret;
   logic        accept;
   logic        sel_to_s;
   logic [1:0]  sel_priv;

   assign take_trap = valid_wb & except_wb.except;
   assign take_ret  = valid_wb & ~except_wb.except & (mret_wb | sret_wb);
   assign accept    = (state_q == IDLE) & ~rst & (take_trap | take_ret);
   assign trap_busy = accept | (state_q != IDLE);
   assign priv      = priv_q;

   trap_target_sel u_target_sel (
      .cur_priv    (priv_q),
      .intr        (except_wb.ecause[63]),
      .idx         (except_wb.ecause[5:0]),
      .medeleg_i   (medeleg_i),
      .mideleg_i   (mideleg_i),
      .to_s        (sel_to_s),
      .target_priv (sel_priv)
   );

   always_comb begin
      state_d        = state_q;
      priv_d         = priv_q;
      new_priv_d     = new_priv_q;
      old_priv_d     = old_priv_q;
      tgt_s_d        = tgt_s_q;
      is_ret_d       = is_ret_q;
      is_mret_d      = is_mret_q;
      epc_d          = epc_q;
      ecause_d       = ecause_q;
      etval_d        = etval_q;
      ret_pc_d       = ret_pc_q;
      csr_we         = 1'b0;
      csr_waddr      = 12'h000;
      csr_wdata      = 64'h0;
      flush_all      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (take_trap) begin
                  state_d    = W_CAUSE;
                  is_ret_d   = 1'b0;
                  tgt_s_d    = sel_to_s;
                  new_priv_d = sel_priv;
                  old_priv_d = priv_q;
                  epc_d      = except_wb.epc;
                  ecause_d   = except_wb.ecause;
                  etval_d    = except_wb.etval;
               end else begin
                  state_d    = R_STATUS;
                  is_ret_d   = 1'b1;
                  is_mret_d  = mret_wb;
               end
            end
         end
         W_CAUSE: begin
            csr_we    = 1'b1;
            csr_waddr = tgt_s_q ? SCAUSE : MCAUSE;
            csr_wdata = ecause_q;
            state_d   = W_EPC;
         end
         W_EPC: begin
            csr_we    = 1'b1;
            csr_waddr = tgt_s_q ? SEPC : MEPC;
            csr_wdata = epc_q;
            state_d   = W_TVAL;
         end
         W_TVAL: begin
            csr_we    = 1'b1;
            csr_waddr = tgt_s_q ? STVAL : MTVAL;
            csr_wdata = etval_q;
            state_d   = W_STATUS;
         end
         W_STATUS: begin
            csr_we    = 1'b1;
            csr_waddr = MSTATUS;
            csr_wdata = trap_status(mstatus_i, tgt_s_q, old_priv_q);
            state_d   = REDIRECT;
         end
         // mstatus is sampled only here so the privilege we return to matches what we write.
         R_STATUS: begin
            csr_we     = 1'b1;
            csr_waddr  = MSTATUS;
            csr_wdata  = ret_status(mstatus_i, is_mret_q);
            new_priv_d = is_mret_q ? mstatus_i[MPP_HI:MPP_LO]
                                   : (mstatus_i[SPP_BIT] ? PRIV_S : PRIV_U);
            ret_pc_d   = is_mret_q ? mepc_i : sepc_i;
            state_d    = REDIRECT;
         end
         REDIRECT: begin
            flush_all      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = is_ret_q ? ret_pc_q
                                      : ((tgt_s_q ? stvec_i : mtvec_i) & ~64'h3);
            priv_d         = new_priv_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         priv_q     <= PRIV_M;
         new_priv_q <= PRIV_M;
         old_priv_q <= PRIV_M;
         tgt_s_q    <= 1'b0;
         is_ret_q   <= 1'b0;
         is_mret_q  <= 1'b0;
         epc_q      <= 64'h0;
         ecause_q   <= 64'h0;
         etval_q    <= 64'h0;
         ret_pc_q   <= 64'h0;
      end else begin
         state_q    <= state_d;
         priv_q     <= priv_d;
         new_priv_q <= new_priv_d;
         old_priv_q <= old_priv_d;
         tgt_s_q    <= tgt_s_d;
         is_ret_q   <= is_ret_d;
         is_mret_q  <= is_mret_d;
         epc_q      <= epc_d;
         ecause_q   <= ecause_d;
         etval_q    <= etval_d;
         ret_pc_q   <= ret_pc_d;
      end
   end

endmodule

// File: tb/tb_trap_commit_unit.sv
// Self-checking bench for trap_commit_unit: per-cycle vector table covering traps,
// delegation, xRETs and back-to-back events, plus a hand-written reset-mid-sequence run.
module tb_trap_commit_unit;
   import ExceptStruct::*;

   localparam logic [63:0] EPC      = 64'h0000_0000_8000_0010;
   localparam logic [63:0] TVAL     = 64'h0000_0000_0000_FFFF;
   localparam logic [63:0] MTVEC    = 64'h0000_0000_8000_0101;
   localparam logic [63:0] MTVEC_PC = 64'h0000_0000_8000_0100;
   localparam logic [63:0] STVEC    = 64'h0000_0000_8020_0000;
   localparam logic [63:0] MEPC_V   = 64'h0000_0000_0000_1000;
   localparam logic [63:0] SEPC_V   = 64'h0000_0000_0000_2000;
   localparam logic [63:0] MSTAT    = 64'h0000_0000_0000_008A;

   logic        clk = 1'b0;
   logic        rst;
   ExceptPack   except_wb;
   logic        valid_wb, mret_wb, sret_wb;
   logic [63:0] mstatus_i, medeleg_i, mideleg_i, mtvec_i, stvec_i, mepc_i, sepc_i;
   logic        csr_we, trap_busy, flush_all, redirect_valid;
   logic [11:0] csr_waddr;
   logic [63:0] csr_wdata, redirect_pc;
   logic [1:0]  priv;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic        rst, vld, exc, mr, sr;
      logic [63:0] cause;
      logic        we;
      logic [11:0] addr;
      logic [63:0] data;
      logic        busy, fl, rv;
      logic [63:0] rpc;
      logic [1:0]  pr;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   trap_commit_unit dut (
      .clk            (clk),
      .rst            (rst),
      .except_wb      (except_wb),
      .valid_wb       (valid_wb),
      .mret_wb        (mret_wb),
      .sret_wb        (sret_wb),
      .mstatus_i      (mstatus_i),
      .medeleg_i      (medeleg_i),
      .mideleg_i      (mideleg_i),
      .mtvec_i        (mtvec_i),
      .stvec_i        (stvec_i),
      .mepc_i         (mepc_i),
      .sepc_i         (sepc_i),
      .csr_we         (csr_we),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .trap_busy      (trap_busy),
      .flush_all      (flush_all),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .priv           (priv)
   );

   function automatic vec_t mk(string n, logic r, logic vld, logic exc, logic mr, logic sr,
                               logic [63:0] cause, logic we, logic [11:0] addr,
                               logic [63:0] data, logic busy, logic fl, logic rv,
                               logic [63:0] rpc, logic [1:0] pr);
      vec_t v;
      v.name = n; v.rst = r; v.vld = vld; v.exc = exc; v.mr = mr; v.sr = sr;
      v.cause = cause; v.we = we; v.addr = addr; v.data = data; v.busy = busy;
      v.fl = fl; v.rv = rv; v.rpc = rpc; v.pr = pr;
      return v;
   endfunction

   task automatic checkField(string name, string field, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, exp);
      end
   endtask

   // Outputs are compared 1 ns after the falling edge, once the new inputs have settled.
   task automatic checkOutput(vec_t v);
      checkField(v.name, "csr_we",         {63'h0, csr_we},         {63'h0, v.we});
      checkField(v.name, "csr_waddr",      {52'h0, csr_waddr},      {52'h0, v.addr});
      checkField(v.name, "csr_wdata",      csr_wdata,               v.data);
      checkField(v.name, "trap_busy",      {63'h0, trap_busy},      {63'h0, v.busy});
      checkField(v.name, "flush_all",      {63'h0, flush_all},      {63'h0, v.fl});
      checkField(v.name, "redirect_valid", {63'h0, redirect_valid}, {63'h0, v.rv});
      checkField(v.name, "redirect_pc",    redirect_pc,             v.rpc);
      checkField(v.name, "priv",           {62'h0, priv},           {62'h0, v.pr});
   endtask

   task automatic applyStimulus(vec_t v);
      @(negedge clk);
      rst              = v.rst;
      valid_wb         = v.vld;
      except_wb.except = v.exc;
      except_wb.ecause = v.cause;
      mret_wb          = v.mr;
      sret_wb          = v.sr;
      #1;
      checkOutput(v);
   endtask

   initial begin
      rst = 1'b1; valid_wb = 1'b0; mret_wb = 1'b0; sret_wb = 1'b0;
      except_wb.except = 1'b0; except_wb.epc = EPC; except_wb.ecause = 64'h0;
      except_wb.etval = TVAL;
      mstatus_i = MSTAT; medeleg_i = 64'h100; mideleg_i = 64'h0;
      mtvec_i = MTVEC; stvec_i = STVEC; mepc_i = MEPC_V; sepc_i = SEPC_V;
      repeat (2) @(negedge clk);

      //               name       rst v e mr sr cause we addr     data       busy fl rv rpc       priv
      vecs.push_back(mk("reset",   0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     0, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("A_acc",   0, 1,1,0,0, 2,  0, 12'h000, 64'h0,     1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("A_cause", 0, 0,0,0,0, 0,  1, 12'h342, 64'h2,     1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("A_epc",   0, 0,0,0,0, 0,  1, 12'h341, EPC,       1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("A_tval",  0, 0,0,0,0, 0,  1, 12'h343, TVAL,      1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("A_stat",  0, 0,0,0,0, 0,  1, 12'h300, 64'h1882,  1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("A_redir", 0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     1, 1,1, MTVEC_PC, PRIV_M));
      vecs.push_back(mk("B_acc",   0, 1,0,1,0, 0,  0, 12'h000, 64'h0,     1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("B_stat",  0, 0,0,0,0, 0,  1, 12'h300, 64'h8A,    1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("B_redir", 0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     1, 1,1, MEPC_V,   PRIV_M));
      vecs.push_back(mk("C_acc",   0, 1,1,0,0, 8,  0, 12'h000, 64'h0,     1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("C_cause", 0, 0,0,0,0, 0,  1, 12'h142, 64'h8,     1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("C_epc",   0, 0,0,0,0, 0,  1, 12'h141, EPC,       1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("C_tval",  0, 0,0,0,0, 0,  1, 12'h143, TVAL,      1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("C_stat",  0, 0,0,0,0, 0,  1, 12'h300, 64'hA8,    1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("C_redir", 0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     1, 1,1, STVEC,    PRIV_U));
      vecs.push_back(mk("D_acc",   0, 1,0,0,1, 0,  0, 12'h000, 64'h0,     1, 0,0, 64'h0,    PRIV_S));
      vecs.push_back(mk("D_stat",  0, 0,0,0,0, 0,  1, 12'h300, 64'hA8,    1, 0,0, 64'h0,    PRIV_S));
      vecs.push_back(mk("D_redir", 0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     1, 1,1, SEPC_V,   PRIV_S));
      vecs.push_back(mk("E_acc",   0, 1,1,1,0, 2,  0, 12'h000, 64'h0,     1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("E_cause", 0, 0,0,0,0, 0,  1, 12'h342, 64'h2,     1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("E_epc",   0, 1,1,0,0, 8,  1, 12'h341, EPC,       1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("E_tval",  0, 0,0,0,0, 0,  1, 12'h343, TVAL,      1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("E_stat",  0, 0,0,0,0, 0,  1, 12'h300, 64'h82,    1, 0,0, 64'h0,    PRIV_U));
      vecs.push_back(mk("E_redir", 0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     1, 1,1, MTVEC_PC, PRIV_U));
      vecs.push_back(mk("F_acc",   0, 1,1,0,0, 8,  0, 12'h000, 64'h0,     1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("F_cause", 0, 0,0,0,0, 0,  1, 12'h342, 64'h8,     1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("F_epc",   0, 0,0,0,0, 0,  1, 12'h341, EPC,       1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("F_tval",  0, 0,0,0,0, 0,  1, 12'h343, TVAL,      1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("F_stat",  0, 0,0,0,0, 0,  1, 12'h300, 64'h1882,  1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("F_redir", 0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     1, 1,1, MTVEC_PC, PRIV_M));
      vecs.push_back(mk("G_novld", 0, 0,1,1,0, 2,  0, 12'h000, 64'h0,     0, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("G_noret", 0, 1,0,0,0, 0,  0, 12'h000, 64'h0,     0, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("H_acc",   0, 1,0,1,1, 0,  0, 12'h000, 64'h0,     1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("H_stat",  0, 0,0,0,0, 0,  1, 12'h300, 64'h8A,    1, 0,0, 64'h0,    PRIV_M));
      vecs.push_back(mk("H_redir", 0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     1, 1,1, MEPC_V,   PRIV_M));
      vecs.push_back(mk("H_idle",  0, 0,0,0,0, 0,  0, 12'h000, 64'h0,     0, 0,0, 64'h0,    PRIV_U));

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Reset lands while the EPC write is on the port: the rest of the sequence must vanish.
      applyStimulus(mk("R_acc",   0, 1,1,0,0, 2, 0, 12'h000, 64'h0, 1, 0,0, 64'h0, PRIV_U));
      applyStimulus(mk("R_cause", 0, 0,0,0,0, 0, 1, 12'h342, 64'h2, 1, 0,0, 64'h0, PRIV_U));
      applyStimulus(mk("R_epc",   1, 0,0,0,0, 0, 1, 12'h341, EPC,   1, 0,0, 64'h0, PRIV_U));
      for (int k = 0; k < 5; k++)
         applyStimulus(mk($sformatf("R_after%0d", k), 0, 0,0,0,0, 0, 0, 12'h000, 64'h0,
                          0, 0,0, 64'h0, PRIV_M));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
